rx_byte_fifo: RTL and testbench

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

---
 rtl/rx_byte_fifo.sv | 103 ++++++++++
 tb/tb_rx_byte_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// Receive-side character FIFO for a UART. Each rising edge of rx_valid is one
// write, and each rising edge of rx_ferr is one framing event. The head is shown first-word-fall-through.
module rx_byte_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                         bclkx8,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_ferr,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overrun,
    output logic                         ferr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 prev_v;
    logic                 prev_f;

    logic wr_evt;
    logic fr_evt;
    logic pop;
    logic wr_accept;
    logic wr_drop;

    assign wr_evt    = rx_valid & ~prev_v;
    assign fr_evt    = rx_ferr & ~prev_f;
    assign rd_valid  = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = rd_en & rd_valid;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
    assign wr_accept = wr_evt & (~full | pop);
    assign wr_drop   = wr_evt & full & ~pop;
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    // The storage has no reset, so the synthesis tool can map it to plain RAM.
    always_ff @(posedge bclkx8) begin
        if (wr_accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // The edge detectors reset high, so a strobe held across reset release is ignored.
    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            prev_v <= 1'b1;
            prev_f <= 1'b1;
        end else begin
            prev_v <= rx_valid;
            prev_f <= rx_ferr;
        end
    end

    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // When a flag is set and cleared in the same cycle, the set takes priority.
    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (fr_evt) begin
                ferr <= 1'b1;
            end else if (clr_err) begin
                ferr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Testbench for rx_byte_fifo. A queue-based reference model predicts the outputs.
// The directed scenarios are followed by randomized traffic.
module tb_rx_byte_fifo;
    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 4;

    logic                 bclkx8 = 1'b0;
    logic                 rst = 1'b1;
    logic [DATA_BITS-1:0] rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic                 rx_ferr = 1'b0;
    logic                 rd_en = 1'b0;
    logic                 clr_err = 1'b0;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 full;
    logic [2:0]           count;
    logic                 overrun;
    logic                 ferr;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DATA_BITS-1:0] q[$];
    bit m_pv = 1'b1;
    bit m_pf = 1'b1;
    bit m_ovr = 1'b0;
    bit m_ferr = 1'b0;

    rx_byte_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .bclkx8  (bclkx8),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr),
        .rd_en   (rd_en),
        .clr_err (clr_err),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .full    (full),
        .count   (count),
        .overrun (overrun),
        .ferr    (ferr)
    );

    always #5 bclkx8 = ~bclkx8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pv = 1'b1;
        m_pf = 1'b1;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    // The model applies one clock edge using the inputs currently driven.
    task automatic tick();
        bit we, fe, pp;
        if (rst) begin
            model_reset();
        end else begin
            we = rx_valid && !m_pv;
            fe = rx_ferr && !m_pf;
            pp = rd_en && (q.size() > 0);
            if (clr_err) begin
                m_ovr = 1'b0;
                m_ferr = 1'b0;
            end
            if (we && q.size() == DEPTH && !pp) m_ovr = 1'b1;
            if (fe) m_ferr = 1'b1;
            if (pp) void'(q.pop_front());
            if (we && q.size() < DEPTH) q.push_back(rx_data);
            m_pv = rx_valid;
            m_pf = rx_ferr;
        end
        @(posedge bclkx8);
        #1;
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [DATA_BITS-1:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : '0;
        chk({tag, ".count"},    32'(count),    32'(n));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(head));
        chk({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
        chk({tag, ".ferr"},     32'(ferr),     32'(m_ferr));
    endtask

    task automatic write_char(input logic [DATA_BITS-1:0] d, input string tag);
        rx_data = d;
        rx_valid = 1'b1;
        tick();
        check_all({tag, ".wr"});
        rx_valid = 1'b0;
        tick();
        check_all({tag, ".idle"});
    endtask

    task automatic pop_char(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_all({tag, ".pop"});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        tick();
        tick();
        check_all("rst_hold");
        rst = 1'b0;
        tick();
        check_all("rst_rel");

        // Single write, visible next cycle, then popped
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        tick();
        chk("a5.rd_data", 32'(rd_data), 32'h A5);
        chk("a5.count", 32'(count), 32'd1);
        check_all("a5");
        rx_valid = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("a5pop.count", 32'(count), 32'd0);
        chk("a5pop.rd_data", 32'(rd_data), 32'h0);
        check_all("a5pop");

        // A strobe held high for five cycles gives a single write
        rx_data = 8'h3C;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("hold");
        end
        rx_valid = 1'b0;
        tick();
        chk("hold.one", 32'(count), 32'd1);
        pop_char("hold");

        // Fill the FIFO, then overrun it, then drain and clear
        for (int i = 1; i <= 4; i++) write_char(8'(i), "fill");
        chk("fill.full", 32'(full), 32'd1);
        write_char(8'h05, "ovr");
        chk("ovr.flag", 32'(overrun), 32'd1);
        chk("ovr.count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain.order", 32'(rd_data), 32'(i));
            pop_char("drain");
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr.ovr", 32'(overrun), 32'd0);
        check_all("clr");

        // A write and a pop in the same cycle while the FIFO is full
        for (int i = 1; i <= 4; i++) write_char(8'(i), "fill2");
        rx_data = 8'h09;
        rx_valid = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en = 1'b0;
        chk("wrpop.count", 32'(count), 32'd4);
        chk("wrpop.ovr", 32'(overrun), 32'd0);
        chk("wrpop.head", 32'(rd_data), 32'h02);
        check_all("wrpop");
        for (int i = 0; i < 3; i++) pop_char("wrpop_drain");
        chk("wrpop.last", 32'(rd_data), 32'h09);
        pop_char("wrpop_last");

        // Ten write/pop pairs, enough to wrap both pointers
        for (int i = 0; i < 10; i++) begin
            write_char(8'(8'h10 + i), "wrap");
            chk("wrap.data", 32'(rd_data), 32'(8'h10 + i));
            pop_char("wrap");
        end
        chk("wrap.empty", 32'(count), 32'd0);

        // A framing event in the same cycle as clr_err: the set takes priority
        rx_ferr = 1'b1;
        clr_err = 1'b1;
        tick();
        rx_ferr = 1'b0;
        clr_err = 1'b0;
        chk("ferr.set", 32'(ferr), 32'd1);
        check_all("ferr");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_all("ferr_clr");

        // Reset asserted mid-operation, with rx_valid held high through reset release
        for (int i = 0; i < 3; i++) write_char(8'(8'h40 + i), "pre_rst");
        rx_ferr = 1'b1;
        tick();
        rst = 1'b1;
        rx_valid = 1'b1;
        #1;
        model_reset();
        chk("mid_rst.count", 32'(count), 32'd0);
        chk("mid_rst.rd_valid", 32'(rd_valid), 32'd0);
        check_all("mid_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("rel_high");
        end
        chk("rel_high.nowr", 32'(count), 32'd0);
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
        tick();
        write_char(8'h77, "after_rel");

        // Randomized traffic checked against the model
        for (int i = 0; i < 600; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = ($urandom_range(0, 2) == 0);
            rd_en    = ($urandom_range(0, 3) == 0);
            rx_ferr  = ($urandom_range(0, 15) == 0);
            clr_err  = ($urandom_range(0, 19) == 0);
            tick();
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
